// File: rtl/paddle_bank_pkg.sv
// Shared types and constants for the paddle bank.
// Optional feature macro: PADDLE_ACCEL_EN (accelerating auto-repeat step).
package paddle_pkg;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_L,
    DIR_R
  } dir_e;

  localparam int ACCEL_MAX_SHIFT = 2;
  localparam int ACCEL_GROUP     = 4;

  // pend is signed and one bit wider than a position.
  function automatic int pend_width(input int pos_w);
    return pos_w + 1;
  endfunction

endpackage

// File: rtl/paddle_bank_channel.sv
// One paddle channel: request accumulation, auto-repeat and frame-tick commit.
// Optional feature macro: PADDLE_ACCEL_EN (repeat step grows every 4 repeats).
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int POS_W      = 10,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 540,
  parameter int POS_INIT   = 270,
  parameter int STEP       = 8,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             freeze,
  input  logic             key_l_flag,
  input  logic             key_r_flag,
  input  logic             key_l_hold,
  input  logic             key_r_hold,
  output logic [POS_W-1:0] pos,
  output logic             moved,
  output logic             at_min,
  output logic             at_max
);

  localparam int PEND_W  = pend_width(POS_W);
  localparam int SUM_W   = PEND_W + 1;
  localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]        DLY_LAST = CNT_W'(REPEAT_DLY - 1);
  localparam logic [CNT_W-1:0]        PER_LAST = CNT_W'(REPEAT_PER - 1);
  localparam logic signed [SUM_W-1:0] STEP_S   = SUM_W'(STEP);
  localparam logic signed [SUM_W-1:0] RANGE_S  = SUM_W'(POS_MAX - POS_MIN);
  localparam logic signed [SUM_W-1:0] MIN_S    = SUM_W'(POS_MIN);
  localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(POS_MAX);

  logic signed [PEND_W-1:0] pend, pend_next;
  logic [CNT_W-1:0]         rep_cnt, cnt_eff, rep_cnt_next;
  logic                     rep_phase, phase_eff, rep_phase_next;
  logic                     rep_fire, same_run;
  dir_e                     rep_dir, hold_dir;
  logic signed [SUM_W-1:0]  step_rep, req, pend_base, pend_sum, pos_sum;
  logic [POS_W-1:0]         pos_next;

`ifdef PADDLE_ACCEL_EN
  localparam int ACC_SAT = ACCEL_GROUP * ACCEL_MAX_SHIFT;
  localparam int ACC_W   = $clog2(ACC_SAT + 1);
  logic [ACC_W-1:0] acc_cnt, acc_eff, acc_next;
`endif

  always_comb begin
    hold_dir = DIR_NONE;
    if (key_l_hold && !key_r_hold)      hold_dir = DIR_L;
    else if (key_r_hold && !key_l_hold) hold_dir = DIR_R;

    // A direction change restarts the hold as if from idle.
    same_run  = (hold_dir != DIR_NONE) && (hold_dir == rep_dir);
    cnt_eff   = same_run ? rep_cnt : '0;
    phase_eff = same_run && rep_phase;
    rep_fire  = (hold_dir != DIR_NONE) &&
                (phase_eff ? (cnt_eff == PER_LAST) : (cnt_eff == DLY_LAST));
    rep_cnt_next   = (hold_dir == DIR_NONE || rep_fire) ? '0 : cnt_eff + CNT_W'(1);
    rep_phase_next = (hold_dir != DIR_NONE) && (phase_eff || rep_fire);

`ifdef PADDLE_ACCEL_EN
    acc_eff  = same_run ? acc_cnt : '0;
    step_rep = STEP_S << (acc_eff / ACC_W'(ACCEL_GROUP));
    acc_next = acc_eff;
    if (hold_dir == DIR_NONE)                   acc_next = '0;
    else if (rep_fire && acc_eff != ACC_W'(ACC_SAT)) acc_next = acc_eff + ACC_W'(1);
`else
    step_rep = STEP_S;
`endif

    req = '0;
    if (key_l_flag && !key_r_flag)      req = -STEP_S;
    else if (key_r_flag && !key_l_flag) req = STEP_S;
    if (rep_fire) req = (hold_dir == DIR_L) ? req - step_rep : req + step_rep;
    if (freeze)   req = '0;

    // On a tick the old pend is committed, so only this cycle's request remains.
    pend_base = frame_tick ? '0 : SUM_W'(pend);
    pend_sum  = pend_base + req;
    if (pend_sum > RANGE_S)       pend_next = PEND_W'(RANGE_S);
    else if (pend_sum < -RANGE_S) pend_next = PEND_W'(-RANGE_S);
    else                          pend_next = PEND_W'(pend_sum);

    pos_sum = $signed(SUM_W'(pos)) + SUM_W'(pend);
    if (pos_sum < MIN_S)      pos_next = POS_W'(MIN_S);
    else if (pos_sum > MAX_S) pos_next = POS_W'(MAX_S);
    else                      pos_next = POS_W'(pos_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos       <= POS_W'(POS_INIT);
      pend      <= '0;
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
      rep_dir   <= DIR_NONE;
      moved     <= 1'b0;
    end else if (freeze) begin
      pend      <= '0;
      rep_cnt   <= '0;
      rep_phase <= 1'b0;
      rep_dir   <= DIR_NONE;
      moved     <= 1'b0;
    end else begin
      pend      <= pend_next;
      rep_cnt   <= rep_cnt_next;
      rep_phase <= rep_phase_next;
      rep_dir   <= hold_dir;
      moved     <= frame_tick && (pos_next != pos);
      if (frame_tick) pos <= pos_next;
    end
  end

`ifdef PADDLE_ACCEL_EN
  always_ff @(posedge clk) begin
    if (rst || freeze) acc_cnt <= '0;
    else               acc_cnt <= acc_next;
  end
`endif

  assign at_min = (pos == POS_W'(POS_MIN));
  assign at_max = (pos == POS_W'(POS_MAX));

endmodule

// File: rtl/paddle_bank.sv
// Bank of N independent paddle channels with frame-synchronous position commit.
// Optional feature macro: PADDLE_ACCEL_EN (accelerating auto-repeat step).
module paddle_bank
  import paddle_pkg::*;
#(
  parameter int N_PLAYERS  = 2,
  parameter int POS_W      = 10,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 540,
  parameter int POS_INIT   = 270,
  parameter int STEP       = 8,
  parameter int REPEAT_DLY = 25_000_000,
  parameter int REPEAT_PER = 5_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic                       freeze,
  input  logic [N_PLAYERS-1:0]       key_l_flag,
  input  logic [N_PLAYERS-1:0]       key_r_flag,
  input  logic [N_PLAYERS-1:0]       key_l_hold,
  input  logic [N_PLAYERS-1:0]       key_r_hold,
  output logic [N_PLAYERS*POS_W-1:0] pos,
  output logic [N_PLAYERS-1:0]       moved,
  output logic [N_PLAYERS-1:0]       at_min,
  output logic [N_PLAYERS-1:0]       at_max
);

  for (genvar i = 0; i < N_PLAYERS; i++) begin : g_ch
    paddle_channel #(
      .POS_W      (POS_W),
      .POS_MIN    (POS_MIN),
      .POS_MAX    (POS_MAX),
      .POS_INIT   (POS_INIT),
      .STEP       (STEP),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .freeze     (freeze),
      .key_l_flag (key_l_flag[i]),
      .key_r_flag (key_r_flag[i]),
      .key_l_hold (key_l_hold[i]),
      .key_r_hold (key_r_hold[i]),
      .pos        (pos[i*POS_W +: POS_W]),
      .moved      (moved[i]),
      .at_min     (at_min[i]),
      .at_max     (at_max[i])
    );
  end

endmodule

// File: tb/tb_paddle_bank.sv
// Self-checking bench for paddle_bank: behavioural per-channel model plus literal pins.
// Build with PADDLE_ACCEL_EN defined to exercise the accelerating repeat step.
module tb_paddle_bank;

  localparam int N        = 2;
  localparam int POS_W    = 10;
  localparam int POS_MIN  = 0;
  localparam int POS_MAX  = 540;
  localparam int POS_INIT = 270;
  localparam int STEP     = 8;
  localparam int DLY      = 4;
  localparam int PER      = 2;
  localparam int RANGE    = POS_MAX - POS_MIN;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               frame_tick = 1'b0;
  logic               freeze = 1'b0;
  logic [N-1:0]       key_l_flag = '0;
  logic [N-1:0]       key_r_flag = '0;
  logic [N-1:0]       key_l_hold = '0;
  logic [N-1:0]       key_r_hold = '0;
  logic [N*POS_W-1:0] pos;
  logic [N-1:0]       moved, at_min, at_max;

  paddle_bank #(
    .N_PLAYERS  (N),
    .POS_W      (POS_W),
    .POS_MIN    (POS_MIN),
    .POS_MAX    (POS_MAX),
    .POS_INIT   (POS_INIT),
    .STEP       (STEP),
    .REPEAT_DLY (DLY),
    .REPEAT_PER (PER)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .freeze     (freeze),
    .key_l_flag (key_l_flag),
    .key_r_flag (key_r_flag),
    .key_l_hold (key_l_hold),
    .key_r_hold (key_r_hold),
    .pos        (pos),
    .moved      (moved),
    .at_min     (at_min),
    .at_max     (at_max)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: position, pending request, current hold length/direction, repeats so far.
  int m_pos[N];
  int m_pend[N];
  int run_len[N];
  int run_dir[N];
  int reps[N];
  bit m_moved[N];

  function automatic int sat_pend(input int v);
    if (v > RANGE)  return RANGE;
    if (v < -RANGE) return -RANGE;
    return v;
  endfunction

  function automatic int clamp_pos(input int v);
    if (v < POS_MIN) return POS_MIN;
    if (v > POS_MAX) return POS_MAX;
    return v;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      int hd, rep, req, n, sh, np;
      if (rst) begin
        m_pos[i] = POS_INIT; m_pend[i] = 0; run_len[i] = 0; run_dir[i] = 0;
        reps[i] = 0; m_moved[i] = 1'b0;
      end else if (freeze) begin
        m_pend[i] = 0; run_len[i] = 0; run_dir[i] = 0; reps[i] = 0; m_moved[i] = 1'b0;
      end else begin
        hd = (key_l_hold[i] && !key_r_hold[i]) ? -1 :
             (key_r_hold[i] && !key_l_hold[i]) ? 1 : 0;
        rep = 0;
        if (hd == 0 || hd != run_dir[i]) begin
          run_len[i] = 0;
          reps[i]    = 0;
        end
        if (hd != 0) begin
          n = run_len[i] + 1;
          if (n == DLY || (n > DLY && (n - DLY) % PER == 0)) begin
`ifdef PADDLE_ACCEL_EN
            sh = reps[i] / 4;
            if (sh > 2) sh = 2;
`else
            sh = 0;
`endif
            rep = hd * (STEP << sh);
            reps[i]++;
          end
          run_len[i] = n;
        end
        run_dir[i] = hd;
        req = rep;
        if (key_l_flag[i] && !key_r_flag[i]) req -= STEP;
        if (key_r_flag[i] && !key_l_flag[i]) req += STEP;
        if (frame_tick) begin
          np         = clamp_pos(m_pos[i] + m_pend[i]);
          m_moved[i] = (np != m_pos[i]);
          m_pos[i]   = np;
          m_pend[i]  = sat_pend(req);
        end else begin
          m_pend[i]  = sat_pend(m_pend[i] + req);
          m_moved[i] = 1'b0;
        end
      end
    end
  end

  logic [N*POS_W-1:0] e_pos;
  logic [N-1:0]       e_moved, e_min, e_max;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        e_pos[i*POS_W +: POS_W] = POS_W'(m_pos[i]);
        e_moved[i] = m_moved[i];
        e_min[i]   = (m_pos[i] == POS_MIN);
        e_max[i]   = (m_pos[i] == POS_MAX);
      end
      total++;
      if (pos !== e_pos) begin
        bad++;
        $display("FAIL model_pos t=%0t got=%h want=%h", $time, pos, e_pos);
      end
      total++;
      if (moved !== e_moved) begin
        bad++;
        $display("FAIL model_moved t=%0t got=%b want=%b", $time, moved, e_moved);
      end
      total++;
      if (at_min !== e_min || at_max !== e_max) begin
        bad++;
        $display("FAIL model_limits t=%0t got=%b/%b want=%b/%b", $time, at_min, at_max, e_min, e_max);
      end
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic int pos_of(input int ch);
    return int'(pos[ch*POS_W +: POS_W]);
  endfunction

  task automatic drive(input logic [N-1:0] lf, input logic [N-1:0] rf, input logic t);
    key_l_flag = lf; key_r_flag = rf; frame_tick = t;
    @(negedge clk);
    key_l_flag = '0; key_r_flag = '0; frame_tick = 1'b0;
  endtask

  task automatic tick();
    drive('0, '0, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("reset_pos0", pos_of(0), 270);
    check("reset_pos1", pos_of(1), 270);
    check("reset_moved", int'(moved), 0);

    // Three right presses on channel 0, one tick.
    repeat (3) drive(2'b00, 2'b01, 1'b0);
    tick();
    check("r3_pos0", pos_of(0), 294);
    check("r3_pos1", pos_of(1), 270);
    check("r3_moved", int'(moved), 1);
    @(negedge clk);
    check("r3_moved_pulse", int'(moved), 0);

    // Drive channel 0 down to the lower limit, then to 8, then clamp.
    repeat (40) drive(2'b01, 2'b00, 1'b0);
    tick();
    check("to_min_pos0", pos_of(0), 0);
    drive(2'b00, 2'b01, 1'b0);
    tick();
    check("at8_pos0", pos_of(0), 8);
    repeat (5) drive(2'b01, 2'b00, 1'b0);
    tick();
    check("clamp_pos0", pos_of(0), 0);
    check("clamp_at_min", int'(at_min[0]), 1);
    drive(2'b01, 2'b00, 1'b0);
    tick();
    check("limit_pos0", pos_of(0), 0);
    check("limit_moved", int'(moved[0]), 0);

    // Auto-repeat on channel 1: repeats at held cycles 4, 6, 8.
    key_r_hold = 2'b10;
    repeat (9) @(negedge clk);
    key_r_hold = '0;
    tick();
    check("hold9_pos1", pos_of(1), 294);
    key_r_hold = 2'b10;
    repeat (20) @(negedge clk);
    key_r_hold = '0;
    tick();
`ifdef PADDLE_ACCEL_EN
    check("hold20_accel_pos1", pos_of(1), 422);
`else
    check("hold20_pos1", pos_of(1), 366);
`endif

    // Opposing flags cancel; a flag on the tick cycle lands at the next tick.
    drive(2'b00, 2'b01, 1'b0);
    tick();
    check("pre_both_pos0", pos_of(0), 8);
    drive(2'b01, 2'b01, 1'b0);
    tick();
    check("both_pos0", pos_of(0), 8);
    check("both_moved", int'(moved[0]), 0);
    drive(2'b00, 2'b01, 1'b1);
    check("tickflag_pos0", pos_of(0), 8);
    tick();
    check("tickflag_next_pos0", pos_of(0), 16);

    // Freeze suppresses and discards requests.
    freeze = 1'b1;
    repeat (4) drive(2'b00, 2'b01, 1'b0);
    tick();
    check("freeze_pos0", pos_of(0), 16);
    check("freeze_moved", int'(moved), 0);
    freeze = 1'b0;
    tick();
    check("unfreeze_pos0", pos_of(0), 16);
    check("unfreeze_moved", int'(moved), 0);

    // Reset with pending motion and an active hold.
    repeat (3) drive(2'b00, 2'b01, 1'b0);
    key_r_hold = 2'b10;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    key_r_hold = '0;
    check("rst_pos0", pos_of(0), 270);
    check("rst_pos1", pos_of(1), 270);
    check("rst_moved", int'(moved), 0);
    tick();
    check("rst_tick_pos0", pos_of(0), 270);
    check("rst_tick_pos1", pos_of(1), 270);

    // Randomised traffic; slow-tick segments push pend into saturation.
    for (int seg = 0; seg < 40; seg++) begin
      int tick_mod;
      tick_mod = (seg % 3 == 0) ? 150 : 5;
      for (int c = 0; c < 100; c++) begin
        key_l_flag = N'($urandom_range(0, (1 << N) - 1)) & N'($urandom_range(0, (1 << N) - 1));
        key_r_flag = N'($urandom_range(0, (1 << N) - 1)) & N'($urandom_range(0, (1 << N) - 1));
        if ($urandom_range(0, 9) == 0) key_l_hold = key_l_hold ^ N'($urandom_range(1, (1 << N) - 1));
        if ($urandom_range(0, 9) == 0) key_r_hold = key_r_hold ^ N'($urandom_range(1, (1 << N) - 1));
        frame_tick = ($urandom_range(0, tick_mod - 1) == 0);
        if ($urandom_range(0, 39) == 0) freeze = ~freeze;
        rst = ($urandom_range(0, 799) == 0);
        @(negedge clk);
      end
    end
    key_l_flag = '0; key_r_flag = '0; key_l_hold = '0; key_r_hold = '0;
    frame_tick = 1'b0; freeze = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
